// File: rtl/otp_cipher_engine.sv
// One-time-pad cipher engine: LFSR-generated pads stored per slot, XOR encrypt/decrypt.
// Optional OTP_PAD_ZEROIZE_EN adds per-slot valid bits, store-full/empty errors and pad clear on decrypt.
module otp_cipher_engine #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LFSR_SEED = 'hA5,
  parameter int unsigned LFSR_TAPS = 'hB8,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_decrypt,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic [IDX_W:0]    pads_used
);

  localparam logic [DATA_W-1:0] SEED      = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] TAPS      = DATA_W'(LFSR_TAPS);
  localparam logic [IDX_W:0]    DEPTH_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_RESULT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_err_q, out_err_d;
  logic [IDX_W:0]    used_q, used_d;
  logic [DATA_W-1:0] pad_q [DEPTH];
  logic [DATA_W-1:0] pad_d [DEPTH];
`ifdef OTP_PAD_ZEROIZE_EN
  logic [DEPTH-1:0]  vld_q, vld_d;
`endif

  logic              enc_err, dec_err;
  logic [DATA_W-1:0] lfsr_nxt, pad_rd;

  assign in_ready  = ena && (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESULT);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_err   = out_err_q;
  assign pads_used = used_q;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    wr_ptr_d   = wr_ptr_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_err_d  = out_err_q;
    used_d     = used_q;
    pad_d      = pad_q;
`ifdef OTP_PAD_ZEROIZE_EN
    vld_d      = vld_q;
    enc_err    = vld_q[wr_ptr_q];
    dec_err    = !vld_q[in_idx];
`else
    enc_err    = 1'b0;
    dec_err    = 1'b0;
`endif
    lfsr_nxt   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    pad_rd     = pad_q[in_idx];

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_RESULT;
            if (!in_decrypt) begin
              out_idx_d = wr_ptr_q;
              if (enc_err) begin
                out_data_d = '0;
                out_err_d  = 1'b1;
              end else begin
                out_data_d       = in_data ^ lfsr_q;
                out_err_d        = 1'b0;
                pad_d[wr_ptr_q]  = lfsr_q;
                lfsr_d           = lfsr_nxt;
                wr_ptr_d         = wr_ptr_q + 1'b1;
`ifdef OTP_PAD_ZEROIZE_EN
                vld_d[wr_ptr_q]  = 1'b1;
                used_d           = used_q + 1'b1;
`else
                if (used_q != DEPTH_CNT) used_d = used_q + 1'b1;
`endif
              end
            end else begin
              out_idx_d = in_idx;
              if (dec_err) begin
                out_data_d = '0;
                out_err_d  = 1'b1;
              end else begin
                out_data_d = in_data ^ pad_rd;
                out_err_d  = 1'b0;
`ifdef OTP_PAD_ZEROIZE_EN
                // Pad is single-use: wipe it once consumed.
                pad_d[in_idx] = '0;
                vld_d[in_idx] = 1'b0;
                used_d        = used_q - 1'b1;
`endif
              end
            end
          end
        end
        S_RESULT: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      wr_ptr_q   <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_err_q  <= 1'b0;
      used_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) pad_q[i] <= '0;
`ifdef OTP_PAD_ZEROIZE_EN
      vld_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      wr_ptr_q   <= wr_ptr_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_err_q  <= out_err_d;
      used_q     <= used_d;
      pad_q      <= pad_d;
`ifdef OTP_PAD_ZEROIZE_EN
      vld_q      <= vld_d;
`endif
    end
  end

endmodule

// File: tb/tb_otp_cipher_engine.sv
// Directed bench for otp_cipher_engine at default parameters; expectations follow OTP_PAD_ZEROIZE_EN.
module tb_otp_cipher_engine;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_decrypt;
  logic [2:0] in_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_err;
  logic [3:0] pads_used;

  int vectors;
  int miscompares;

  otp_cipher_engine #(
    .DATA_W   (8),
    .DEPTH    (8),
    .LFSR_SEED('hA5),
    .LFSR_TAPS('hB8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_decrypt(in_decrypt),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .pads_used (pads_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    ena        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_decrypt = 1'b0;
    in_idx     = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for in_ready, leave the result pending.
  task automatic send(input logic dec, input logic [2:0] idx, input logic [7:0] data);
    int n;
    n          = 0;
    in_valid   = 1'b1;
    in_decrypt = dec;
    in_idx     = idx;
    in_data    = data;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 3'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b data=%h idx=%0d err=%b required 0/00/0/0",
               out_valid, out_data, out_idx, out_err);
    end
    vectors++;
    if (pads_used !== 4'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: pads_used=%0d in_ready=%b required 0/1", pads_used, in_ready);
    end
  endtask

  task automatic test_encrypt();
    send(1'b0, 3'd0, 8'h3C);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h99 || out_idx !== 3'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL enc_first: valid=%b data=%h idx=%0d err=%b required 1/99/0/0",
               out_valid, out_data, out_idx, out_err);
    end
    consume();
    send(1'b0, 3'd5, 8'h00);
    vectors++;
    if (out_data !== 8'hEA || out_idx !== 3'd1 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL enc_second: data=%h idx=%0d err=%b required EA/1/0", out_data, out_idx, out_err);
    end
    consume();
    vectors++;
    if (pads_used !== 4'd2) begin
      miscompares++;
      $display("FAIL enc_pads_used: got %0d required 2", pads_used);
    end
  endtask

  task automatic test_decrypt_hold();
    send(1'b1, 3'd0, 8'h99);
    vectors++;
    if (out_data !== 8'h3C || out_idx !== 3'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_data: data=%h idx=%0d err=%b required 3C/0/0", out_data, out_idx, out_err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL dec_hold%0d: valid=%b data=%h in_ready=%b required 1/3C/0",
                 i, out_valid, out_data, in_ready);
      end
    end
    consume();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_release: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_repeat_decrypt();
    send(1'b1, 3'd0, 8'h99);
    vectors++;
`ifdef OTP_PAD_ZEROIZE_EN
    if (out_err !== 1'b1 || out_data !== 8'h00 || out_idx !== 3'd0 || pads_used !== 4'd1) begin
      miscompares++;
      $display("FAIL dec_repeat: err=%b data=%h idx=%0d used=%0d required 1/00/0/1",
               out_err, out_data, out_idx, pads_used);
    end
`else
    if (out_err !== 1'b0 || out_data !== 8'h3C || out_idx !== 3'd0 || pads_used !== 4'd2) begin
      miscompares++;
      $display("FAIL dec_repeat: err=%b data=%h idx=%0d used=%0d required 0/3C/0/2",
               out_err, out_data, out_idx, pads_used);
    end
`endif
    consume();
  endtask

  task automatic test_full_wrap();
    logic [7:0] pads [0:8];
    pads[0] = 8'hA5; pads[1] = 8'hEA; pads[2] = 8'h75; pads[3] = 8'h82; pads[4] = 8'h41;
    pads[5] = 8'h98; pads[6] = 8'h4C; pads[7] = 8'h26; pads[8] = 8'h13;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 3'd0, 8'h00);
      vectors++;
      if (out_data !== pads[i] || out_idx !== 3'(i) || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_enc%0d: data=%h idx=%0d err=%b required %h/%0d/0",
                 i, out_data, out_idx, out_err, pads[i], i);
      end
      consume();
    end
    vectors++;
    if (pads_used !== 4'd8) begin
      miscompares++;
      $display("FAIL wrap_used8: got %0d required 8", pads_used);
    end
    send(1'b0, 3'd0, 8'h00);
    vectors++;
`ifdef OTP_PAD_ZEROIZE_EN
    if (out_err !== 1'b1 || out_data !== 8'h00 || out_idx !== 3'd0 || pads_used !== 4'd8) begin
      miscompares++;
      $display("FAIL wrap_ninth: err=%b data=%h idx=%0d used=%0d required 1/00/0/8",
               out_err, out_data, out_idx, pads_used);
    end
    consume();
    send(1'b1, 3'd0, 8'h00);
    vectors++;
    if (out_data !== 8'hA5 || out_err !== 1'b0 || pads_used !== 4'd7) begin
      miscompares++;
      $display("FAIL wrap_clear0: data=%h err=%b used=%0d required A5/0/7", out_data, out_err, pads_used);
    end
    consume();
    send(1'b0, 3'd0, 8'h00);
    vectors++;
    if (out_data !== pads[8] || out_idx !== 3'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_lfsr_held: data=%h idx=%0d err=%b required 13/0/0", out_data, out_idx, out_err);
    end
`else
    if (out_err !== 1'b0 || out_data !== pads[8] || out_idx !== 3'd0 || pads_used !== 4'd8) begin
      miscompares++;
      $display("FAIL wrap_ninth: err=%b data=%h idx=%0d used=%0d required 0/13/0/8",
               out_err, out_data, out_idx, pads_used);
    end
    consume();
    send(1'b1, 3'd0, 8'h00);
    vectors++;
    if (out_data !== pads[8] || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_overwrite: data=%h err=%b required 13/0", out_data, out_err);
    end
`endif
    consume();
  endtask

  task automatic test_reset_mid_result();
    send(1'b0, 3'd0, 8'h55);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid: valid=%b data=%h required 0/00", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 3'd3, 8'h00);
    vectors++;
    if (out_data !== 8'hA5 || out_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid_pad: data=%h idx=%0d required A5/0", out_data, out_idx);
    end
    consume();
  endtask

  task automatic test_ena_gate();
    do_reset();
    ena        = 1'b0;
    in_valid   = 1'b1;
    in_decrypt = 1'b0;
    in_data    = 8'h00;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_ready: in_ready=%b required 0", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_no_accept: out_valid=%b required 0", out_valid);
    end
    ena = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL ena_accept: valid=%b data=%h idx=%0d required 1/A5/0", out_valid, out_data, out_idx);
    end
    ena       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL ena_hold_result: valid=%b data=%h required 1/A5", out_valid, out_data);
    end
    ena = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ena_release: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    send(1'b0, 3'd0, 8'hFF);
    vectors++;
    if (out_data !== 8'h15 || out_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL b2b_enc: data=%h idx=%0d required 15/1", out_data, out_idx);
    end
    consume();
    send(1'b1, 3'd1, 8'h15);
    vectors++;
    if (out_data !== 8'hFF || out_idx !== 3'd1 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_dec: data=%h idx=%0d err=%b required FF/1/0", out_data, out_idx, out_err);
    end
    consume();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_encrypt();
    test_decrypt_hold();
    test_repeat_decrypt();
    test_full_wrap();
    test_reset_mid_result();
    test_ena_gate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/otp_cipher_engine.md
OTP_CIPHER_ENGINE -- requirements
Module: otp_cipher_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the data and pad width in bits (≥4).
REQ-002 SHALL have parameter DEPTH, default 8, giving the number of pad slots (power of 2, ≥2); IDX_W = log2(DEPTH) is a local derived width.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, giving the nonzero LFSR reset value, truncated to DATA_W.
REQ-004 SHALL have parameter LFSR_TAPS, default 8'hB8, giving the Galois feedback mask, truncated to DATA_W.
REQ-005 SHALL have the following ports (one per line: name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  ena  in  1  design enable; low freezes all state
  in_valid  in  1  request valid
  in_ready  out  1  request accepted when high with in_valid
  in_data  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt)
  in_decrypt  in  1  1 = decrypt, 0 = encrypt
  in_idx  in  IDX_W  pad slot for decrypt; ignored on encrypt
  out_valid  out  1  result valid
  out_ready  in  1  result consumed when high with out_valid
  out_data  out  DATA_W  in_data XOR pad, or 0 on error
  out_idx  out  IDX_W  pad slot used
  out_err  out  1  request rejected
  pads_used  out  IDX_W+1  occupied-slot count

Function
REQ-006 SHALL implement a 2-state FSM: IDLE and RESULT.
REQ-007 in_ready SHALL equal ena AND (state==IDLE); out_valid SHALL be high exactly in RESULT.
REQ-008 On an IDLE edge with ena, in_valid and in_ready high, the block SHALL register out_data, out_idx and out_err and enter RESULT (1-cycle latency).
REQ-009 In RESULT with ena and out_ready high, the FSM SHALL return to IDLE on the next edge; results SHALL hold stable until then. Peak throughput is one request per 2 cycles.
REQ-010 With ena low, the FSM, LFSR, pointers and pad store SHALL hold, and outputs SHALL retain their values.
REQ-011 Encrypt SHALL use pad = current LFSR state, write it to slot wr_ptr, output in_data^pad with out_idx=wr_ptr, then set wr_ptr=(wr_ptr+1) mod DEPTH.
REQ-012 The LFSR SHALL advance only on a successful encrypt: next = (s>>1) XOR (s[0] ? LFSR_TAPS : 0).
REQ-013 Decrypt SHALL output in_data ^ pad[in_idx] with out_idx=in_idx; the LFSR and wr_ptr SHALL be unchanged.
REQ-014 On error, out_data SHALL be 0, out_idx SHALL be the rejected slot, and no state other than the FSM SHALL change.

Reset
REQ-015 rst_n low SHALL asynchronously set: state IDLE, out_valid 0, out_data 0, out_idx 0, out_err 0, wr_ptr 0, LFSR=LFSR_SEED, all pad slots 0, all valid bits 0, pads_used 0.
REQ-016 Reset asserted in RESULT SHALL drop out_valid immediately and discard the pending result.

Configuration
REQ-017 Macro OTP_PAD_ZEROIZE_EN defined: each slot SHALL have a valid bit. Encrypt to a valid wr_ptr slot SHALL raise out_err (store full). Decrypt of an invalid slot SHALL raise out_err. A successful decrypt SHALL clear the slot to 0 and its valid bit. pads_used SHALL equal the count of set valid bits.
REQ-018 Macro OTP_PAD_ZEROIZE_EN undefined: out_err SHALL be constant 0. Encrypt SHALL always overwrite wr_ptr and wrap. Decrypt SHALL read without clearing. pads_used SHALL count encrypts, saturating at DEPTH.

Verification (defaults DATA_W=8, DEPTH=8, SEED=A5, TAPS=B8)
REQ-019 Reset, then encrypt 3C -> out_data 99, out_idx 0, err 0; next encrypt 00 -> out_data EA, out_idx 1; pads_used=2.
REQ-020 After REQ-019, decrypt idx 0 with data 99 -> out_data 3C; hold out_ready low 3 cycles -> out_valid and out_data stable, in_ready 0.
REQ-021 With ZEROIZE: repeat the decrypt of idx 0 -> out_err 1, out_data 00, pads_used=1. Without it -> out_data 3C, err 0.
REQ-022 Nine encrypts from reset: with ZEROIZE, ninth -> err 1 and LFSR unchanged; without, ninth -> out_idx 0 and pads_used=8.
REQ-023 Assert rst_n low mid-RESULT -> out_valid 0 immediately; after release, first encrypt uses pad A5 at idx 0.
REQ-024 Drop ena while in_valid is high -> in_ready 0, no acceptance, LFSR frozen; raise ena -> request accepted next edge.
